// File: rtl/ecc_secded_pkg.sv
// ecc_secded_pkg: shared types and constant helpers for the
// SECDED decoder pipeline and its parity generator.
package ecc_secded_pkg;

    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ECC_CLEAN,
        ECC_SBE_DATA,
        ECC_SBE_CHK,
        ECC_DBE
    } ecc_class_e;

    function automatic int calc_p_bits(input int width);
        int p;
        p = 1;
        while ((1 << p) < width + p + 1) p++;
        return p;
    endfunction

    // k-th data bit lands on the (k+1)-th non-power-of-two >= 3
    function automatic int data_pos(input int k);
        int pos;
        pos = 2;
        for (int i = 0; i <= k; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// ecc_secded_pipe_if: valid/ready stream bundle for the decoder,
// read word in and corrected word plus status out.
interface ecc_secded_pipe_if
    import ecc_secded_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    localparam int P_BITS   = calc_p_bits(DATA_WIDTH);
    localparam int ECC_BITS = P_BITS + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ECC_BITS-1:0]   in_ecc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sbe;
    logic                  out_dbe;
    logic [P_BITS-1:0]     out_syndrome;

    modport master (
        output in_valid, in_data, in_ecc, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_sbe, out_dbe, out_syndrome
    );

    modport slave (
        input  in_valid, in_data, in_ecc, out_ready,
        output in_ready, out_valid, out_data,
        output out_sbe, out_dbe, out_syndrome
    );

endinterface

// File: rtl/ecc_secded_gen.sv
// ecc_secded_gen: combinational Hamming parity generator,
// data -> {g, p}; shared by the read decoder and write encoder.
module ecc_secded_gen
    import ecc_secded_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]              data,
    output logic [calc_p_bits(DATA_WIDTH):0]   ecc
);
    localparam int P_BITS = calc_p_bits(DATA_WIDTH);

    logic [P_BITS-1:0] p;

    for (genvar j = 0; j < P_BITS; j++) begin : g_p
        logic [DATA_WIDTH-1:0] m;
        for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_m
            localparam int POS = data_pos(k);
            assign m[k] = POS[j];
        end
        assign p[j] = ^(data & m);
    end

    assign ecc = {(^data) ^ (^p), p};

endmodule

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: 2-stage SECDED decoder with saturating SBE/DBE
// counters; ECC_SECDED_PIPE_INJECT_EN adds the inj_mask error port.
module ecc_secded_pipe
    import ecc_secded_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ecc_secded_pipe_if.slave     bus,
`ifdef ECC_SECDED_PIPE_INJECT_EN
    input  logic [DATA_WIDTH+calc_p_bits(DATA_WIDTH):0] inj_mask,
`endif
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] sbe_count,
    output logic [CNT_WIDTH-1:0] dbe_count
);
    localparam int DW       = DATA_WIDTH;
    localparam int P_BITS   = calc_p_bits(DW);
    localparam int ECC_BITS = P_BITS + 1;

    logic adv;
    assign adv = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    logic [DW-1:0]       rx_data;
    logic [ECC_BITS-1:0] rx_ecc;
`ifdef ECC_SECDED_PIPE_INJECT_EN
    assign {rx_ecc, rx_data} = {bus.in_ecc, bus.in_data} ^ inj_mask;
`else
    assign {rx_ecc, rx_data} = {bus.in_ecc, bus.in_data};
`endif

    logic [ECC_BITS-1:0] calc_ecc;

    ecc_secded_gen #(.DATA_WIDTH(DW)) u_gen (
        .data (rx_data),
        .ecc  (calc_ecc)
    );

    // overall parity of the received word, folded through the syndrome
    logic [P_BITS-1:0] syn_d;
    logic              e_d;
    assign syn_d = calc_ecc[P_BITS-1:0] ^ rx_ecc[P_BITS-1:0];
    assign e_d   = calc_ecc[P_BITS] ^ rx_ecc[P_BITS] ^ (^syn_d);

    logic              s1_valid;
    logic [DW-1:0]     s1_data;
    logic [P_BITS-1:0] s1_syn;
    logic              s1_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_e     <= 1'b0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_data  <= rx_data;
            s1_syn   <= syn_d;
            s1_e     <= e_d;
        end
    end

    logic [DW-1:0] flip;
    for (genvar k = 0; k < DW; k++) begin : g_flip
        localparam int POS = data_pos(k);
        assign flip[k] = (s1_syn == POS[P_BITS-1:0]);
    end

    logic chk_hit;
    assign chk_hit = (s1_syn & (s1_syn - P_BITS'(1))) == '0;

    ecc_class_e cls;
    always_comb begin
        cls = ECC_CLEAN;
        unique case (1'b1)
            !s1_e && s1_syn == '0:          cls = ECC_CLEAN;
            !s1_e && s1_syn != '0:          cls = ECC_DBE;
            s1_e && chk_hit:                cls = ECC_SBE_CHK;
            s1_e && !chk_hit && (|flip):    cls = ECC_SBE_DATA;
            s1_e && !chk_hit && !(|flip):   cls = ECC_DBE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_sbe      <= 1'b0;
            bus.out_dbe      <= 1'b0;
            bus.out_syndrome <= '0;
        end else if (adv) begin
            bus.out_valid    <= s1_valid;
            bus.out_data     <= (cls == ECC_SBE_DATA) ?
                                s1_data ^ flip : s1_data;
            bus.out_sbe      <= (cls == ECC_SBE_DATA) ||
                                (cls == ECC_SBE_CHK);
            bus.out_dbe      <= (cls == ECC_DBE);
            bus.out_syndrome <= s1_syn;
        end
    end

    logic hs;
    assign hs = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_count <= '0;
            dbe_count <= '0;
        end else if (cnt_clr) begin
            sbe_count <= '0;
            dbe_count <= '0;
        end else if (hs) begin
            if (bus.out_sbe && !(&sbe_count))
                sbe_count <= sbe_count + CNT_WIDTH'(1);
            if (bus.out_dbe && !(&dbe_count))
                dbe_count <= dbe_count + CNT_WIDTH'(1);
        end
    end

endmodule
